// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default widths for the data cache controller
package cache_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_RD = 3'd1,
        ST_FILL   = 3'd2,
        ST_RESP   = 3'd3,
        ST_MEM_WR = 3'd4
    } state_e;

endpackage

// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU, cache-array and memory signals of the data cache controller
interface dcache_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [DATA_WIDTH-1:0] cpu_wdata_i;
    logic [DATA_WIDTH-1:0] cpu_rdata_o;
    logic                  cpu_stall_o;
    logic [ADDR_WIDTH-1:0] cache_addr_o;
    logic [DATA_WIDTH-1:0] cache_wdata_o;
    logic                  cache_fill_o;
    logic                  cache_overwrite_o;
    logic                  cache_hit_i;
    logic [DATA_WIDTH-1:0] cache_rdata_i;
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ready_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic [CNT_WIDTH-1:0]  hit_count_o;
    logic [CNT_WIDTH-1:0]  miss_count_o;

    // Controller side
    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cache_hit_i, cache_rdata_i, mem_ready_i, mem_rdata_i,
        output cpu_rdata_o, cpu_stall_o, cache_addr_o, cache_wdata_o,
        output cache_fill_o, cache_overwrite_o, mem_req_o, mem_we_o,
        output mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o
    );

    // CPU, cache array and memory side
    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cache_hit_i, cache_rdata_i, mem_ready_i, mem_rdata_i,
        input  cpu_rdata_o, cpu_stall_o, cache_addr_o, cache_wdata_o,
        input  cache_fill_o, cache_overwrite_o, mem_req_o, mem_we_o,
        input  mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o
    );

endinterface

// File: rtl/dcache_controller_sat_counter.sv
// rtl/dcache_controller_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc and stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - write-through, read-allocate sequencer for a 2-way data cache
module dcache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    dcache_controller_if.master bus
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  capture;
    logic                  latch_rd;
    logic                  hit_inc;
    logic                  miss_inc;
    logic                  stall;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] cache_addr;
    logic [DATA_WIDTH-1:0] cache_wdata;
    logic                  fill;
    logic                  overwrite;
    logic                  mem_req;
    logic                  mem_we;

    // State, captured request and latched memory read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                // Word aligned: the byte offset never reaches memory
                addr_q  <= {bus.cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                wdata_q <= bus.cpu_wdata_i;
            end
            if (latch_rd) begin
                rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    // Next state and per-state outputs; hits complete in IDLE with no extra cycle
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        rdata       = '0;
        cache_addr  = (state_q == ST_IDLE) ? bus.cpu_addr_i : addr_q;
        cache_wdata = '0;
        fill        = 1'b0;
        overwrite   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        capture     = 1'b0;
        latch_rd    = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (bus.cpu_we_i) begin
                        // Write-through: keep a hitting line coherent, never allocate
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = ST_MEM_WR;
                        if (bus.cache_hit_i) begin
                            overwrite   = 1'b1;
                            cache_wdata = bus.cpu_wdata_i;
                        end
                    end else if (bus.cache_hit_i) begin
                        rdata   = bus.cache_rdata_i;
                        hit_inc = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        capture  = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = ST_MEM_RD;
                    end
                end
            end
            ST_MEM_RD: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (bus.mem_ready_i) begin
                    latch_rd = 1'b1;
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                fill        = 1'b1;
                cache_wdata = rdata_q;
                stall       = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                rdata   = rdata_q;
                state_d = ST_IDLE;
            end
            ST_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = ~bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (bus.hit_count_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (bus.miss_count_o)
    );

    assign bus.cpu_rdata_o       = rdata;
    assign bus.cpu_stall_o       = stall;
    assign bus.cache_addr_o      = cache_addr;
    assign bus.cache_wdata_o     = cache_wdata;
    assign bus.cache_fill_o      = fill;
    assign bus.cache_overwrite_o = overwrite;
    assign bus.mem_req_o         = mem_req;
    assign bus.mem_we_o          = mem_we;
    assign bus.mem_addr_o        = addr_q;
    assign bus.mem_wdata_o       = wdata_q;

    // Fill happens only in FILL and overwrite only in IDLE, so they can never coincide
    a_fill_overwrite_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(fill && overwrite)
    );

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
    dcache_controller_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(2))  sbus ();

    dcache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dcache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEAD_BEEF : (32'hA500_0000 + 32'(i));
    endfunction

    // Environment: cache array (any address can be held), memory with programmable latency
    logic [31:0] mem [64];
    logic [31:0] cd  [64];
    logic        cv  [64];
    logic        model_init  = 1'b1;
    logic        force_ready = 1'b0;
    int          mem_lat     = 1;
    int          wcnt        = 0;

    assign bus.cache_hit_i   = cv[bus.cache_addr_o[7:2]];
    assign bus.cache_rdata_i = cd[bus.cache_addr_o[7:2]];
    assign bus.mem_ready_i   = (bus.mem_req_o && (wcnt == mem_lat - 1)) || force_ready;
    assign bus.mem_rdata_i   = mem[bus.mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (rst || !bus.mem_req_o || bus.mem_ready_i) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= init_word(i);
                cv[i]  <= 1'b0;
                cd[i]  <= 32'h0;
            end
        end else begin
            if (bus.cache_fill_o) begin
                cv[bus.cache_addr_o[7:2]] <= 1'b1;
                cd[bus.cache_addr_o[7:2]] <= bus.cache_wdata_o;
            end
            if (bus.cache_overwrite_o && cv[bus.cache_addr_o[7:2]])
                cd[bus.cache_addr_o[7:2]] <= bus.cache_wdata_o;
            if (bus.mem_req_o && bus.mem_ready_i && bus.mem_we_o)
                mem[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
        end
    end

    assign sbus.cache_hit_i   = 1'b1;
    assign sbus.cache_rdata_i = 32'h5A5A_0001;
    assign sbus.mem_ready_i   = 1'b0;
    assign sbus.mem_rdata_i   = 32'h0;

    // Reference model: CPU-visible memory image and set of words the cache holds
    logic [31:0] golden  [64];
    bit          present [64];
    int          exp_hits = 0, exp_misses = 0;

    // Expectations for the access in flight
    bit          active = 0, done = 0;
    int          cyc = 0, exp_lat = 0, exp_memc = 0, last_lat = 0, fills = 0;
    bit          exp_we, exp_ovw, exp_fill;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, last_fill_data;

    // Compare process: every cycle of an access, plus counters whenever the port is idle
    always @(negedge clk) begin
        chk("fill_with_mem_req", 32'(bus.mem_req_o & bus.cache_fill_o), 32'd0);
        if (!rst && active) begin
            chk("mem_req_window", 32'(bus.mem_req_o), 32'(cyc >= 1 && cyc <= exp_memc));
            if (bus.mem_req_o) begin
                chk("mem_we", 32'(bus.mem_we_o), 32'(exp_we));
                chk("mem_addr", bus.mem_addr_o, exp_addr);
                if (exp_we) chk("mem_wdata", bus.mem_wdata_o, exp_wdata);
            end
            chk("overwrite", 32'(bus.cache_overwrite_o), 32'(exp_ovw && cyc == 0));
            if (bus.cache_overwrite_o) chk("overwrite_data", bus.cache_wdata_o, exp_wdata);
            chk("fill", 32'(bus.cache_fill_o), 32'(exp_fill && cyc == exp_lat - 2));
            if (bus.cache_fill_o) begin
                fills++;
                last_fill_data = bus.cache_wdata_o;
                chk("fill_data", bus.cache_wdata_o, exp_rdata);
            end
            chk("stall", 32'(bus.cpu_stall_o), 32'(cyc != exp_lat - 1));
            if (!bus.cpu_stall_o || cyc > 60) begin
                if (!exp_we) chk("load_rdata", bus.cpu_rdata_o, exp_rdata);
                last_lat = cyc + 1;
                active   = 0;
                done     = 1;
            end else begin
                cyc++;
            end
        end else if (!rst && !bus.cpu_req_i) begin
            chk("hit_count", 32'(bus.hit_count_o), 32'(exp_hits));
            chk("miss_count", 32'(bus.miss_count_o), 32'(exp_misses));
            chk("idle_stall", 32'(bus.cpu_stall_o), 32'd0);
        end
    end

    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        int idx;
        idx = int'(addr[7:2]);
        @(posedge clk);
        exp_we    = we;
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = wd;
        exp_ovw   = we && present[idx];
        exp_fill  = !we && !present[idx];
        if (we) begin
            exp_lat     = lat + 1;
            exp_memc    = lat;
            golden[idx] = wd;
        end else if (present[idx]) begin
            exp_lat  = 1;
            exp_memc = 0;
            exp_hits++;
        end else begin
            exp_lat      = lat + 3;
            exp_memc     = lat;
            present[idx] = 1;
            exp_misses++;
        end
        exp_rdata = golden[idx];
        mem_lat   = lat;
        fills     = 0;
        cyc       = 0;
        done      = 0;
        active    = 1;
        #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        for (int i = 0; i < 80 && !done; i++) @(posedge clk);
        if (!done) begin
            chk("access_timeout", 32'(done), 32'd1);
            active = 0;
        end
        #1;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            golden[i]  = init_word(i);
            present[i] = 0;
        end
        bus.cpu_req_i    = 1'b0;
        bus.cpu_we_i     = 1'b0;
        bus.cpu_addr_i   = 32'h0000_1234;
        bus.cpu_wdata_i  = 32'h0;
        sbus.cpu_req_i   = 1'b0;
        sbus.cpu_we_i    = 1'b0;
        sbus.cpu_addr_i  = 32'h0000_0010;
        sbus.cpu_wdata_i = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.cpu_stall_o), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_fill", 32'(bus.cache_fill_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        chk("rst_rdata", bus.cpu_rdata_o, 32'd0);
        chk("rst_hits", 32'(bus.hit_count_o), 32'd0);
        chk("rst_cache_addr", bus.cache_addr_o, 32'h0000_1234);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        model_init = 1'b0;

        // Cold load miss: ready on the third request cycle
        access(0, 32'h0000_0040, 32'h0, 3);
        chk("miss1_latency", 32'(last_lat), 32'd6);
        chk("miss1_fill_pulses", 32'(fills), 32'd1);
        chk("miss1_fill_data", last_fill_data, 32'hDEAD_BEEF);
        chk("miss1_count", 32'(bus.miss_count_o), 32'd1);

        // Same word again: zero-latency hit
        access(0, 32'h0000_0040, 32'h0, 3);
        chk("hit1_latency", 32'(last_lat), 32'd1);
        chk("hit1_count", 32'(bus.hit_count_o), 32'd1);

        // Store hit, then read it back through the cache
        access(1, 32'h0000_0040, 32'h1234_5678, 2);
        chk("st_hit_latency", 32'(last_lat), 32'd3);
        chk("st_hit_mem", mem[16], 32'h1234_5678);
        access(0, 32'h0000_0040, 32'h0, 2);
        chk("hit2_latency", 32'(last_lat), 32'd1);
        chk("hit2_count", 32'(bus.hit_count_o), 32'd2);

        // Store miss: memory only, no allocation; the next load must miss
        access(1, 32'h0000_0080, 32'hCAFE_F00D, 1);
        chk("st_miss_mem", mem[32], 32'hCAFE_F00D);
        chk("st_miss_no_alloc", 32'(cv[32]), 32'd0);
        access(0, 32'h0000_0080, 32'h0, 2);
        chk("miss2_latency", 32'(last_lat), 32'd5);
        chk("miss2_count", 32'(bus.miss_count_o), 32'd2);

        // Byte offset ignored: 0x83 hits the word at 0x80
        access(0, 32'h0000_0083, 32'h0, 2);
        chk("hit3_latency", 32'(last_lat), 32'd1);

        // Reset while waiting on memory
        @(posedge clk);
        mem_lat = 100;
        #1;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_00C0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mrd_before_rst", 32'(bus.mem_req_o), 32'd1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.cpu_req_i = 1'b0;
        exp_hits      = 0;
        exp_misses    = 0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mid_miss", 32'(bus.miss_count_o), 32'd0);
        chk("rst_mid_hits", 32'(bus.hit_count_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_mid_no_fill", 32'(bus.cache_fill_o), 32'd0);
            chk("rst_mid_no_req", 32'(bus.mem_req_o), 32'd0);
        end
        chk("rst_mid_not_cached", 32'(cv[48]), 32'd0);
        #1;
        force_ready = 1'b0;
        access(0, 32'h0000_00C0, 32'h0, 4);
        chk("miss3_latency", 32'(last_lat), 32'd7);
        chk("miss3_count", 32'(bus.miss_count_o), 32'd1);

        // Two-bit counters: five consecutive hits stop at 3
        @(posedge clk);
        #1;
        sbus.cpu_req_i = 1'b1;
        @(negedge clk);
        chk("sat_rdata", sbus.cpu_rdata_o, 32'h5A5A_0001);
        chk("sat_stall", 32'(sbus.cpu_stall_o), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("sat_hit_count", 32'(sbus.hit_count_o), 32'((k < 3) ? k : 3));
        end
        chk("sat_miss_count", 32'(sbus.miss_count_o), 32'd0);
        #1;
        sbus.cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
